// File: rtl/cnt_ctrl.sv
// Job sequencer driving the load/enable inputs of a loadable WIDTH-bit up-counter.
// Optional abort support is compiled in with `define CNT_CTRL_ABORT_EN.
module cnt_ctrl #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [WIDTH-1:0] req_start,
   input  logic [WIDTH-1:0] req_limit,
   output logic             req_ready,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_out,
   output logic [WIDTH-1:0] cnt_in,
   output logic             load,
   output logic             enab,
   output logic             busy,
   output logic             done,
   output logic             wrapped
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] cnt_in_q;
   logic [WIDTH-1:0] limit_q;
   logic             wrapped_q;
   logic             load_q;
   logic             busy_q;
   logic             done_q;
   logic             ready_q;

   logic             at_limit;
   logic             all_ones;
   logic             abort_hit;

   assign at_limit = (cnt_out == limit_q);
   assign all_ones = &cnt_out;

`ifdef CNT_CTRL_ABORT_EN
   assign abort_hit = abort && ((state_q == S_LOAD) || (state_q == S_RUN));
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_hit    = 1'b0;
`endif

   // The counter must stop in the same cycle an abort is seen, hence the gating here.
   assign enab      = (state_q == S_RUN) && !pause && !at_limit && !abort_hit;
   assign load      = load_q && !abort_hit;
   assign cnt_in    = cnt_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrapped   = wrapped_q;
   assign req_ready = ready_q;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_in_q  <= '0;
         limit_q   <= '0;
         wrapped_q <= 1'b0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  state_q   <= S_LOAD;
                  cnt_in_q  <= req_start;
                  limit_q   <= req_limit;
                  wrapped_q <= 1'b0;
                  load_q    <= 1'b1;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
               end
            end
            S_LOAD: begin
               load_q <= 1'b0;
               if (abort_hit) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort_hit) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  if (enab && all_ones) begin
                     wrapped_q <= 1'b1;
                  end
                  if (at_limit) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               load_q  <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed bench for cnt_ctrl with a behavioural model of the downstream counter.
// Abort expectations follow whether CNT_CTRL_ABORT_EN is defined.
module tb_cnt_ctrl;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic [W-1:0] req_start;
   logic [W-1:0] req_limit;
   logic         req_ready;
   logic         pause;
   logic         abort;
   logic [W-1:0] cnt_out;
   logic [W-1:0] cnt_in;
   logic         load;
   logic         enab;
   logic         busy;
   logic         done;
   logic         wrapped;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   cnt_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_start (req_start),
      .req_limit (req_limit),
      .req_ready (req_ready),
      .pause     (pause),
      .abort     (abort),
      .cnt_out   (cnt_out),
      .cnt_in    (cnt_in),
      .load      (load),
      .enab      (enab),
      .busy      (busy),
      .done      (done),
      .wrapped   (wrapped)
   );

   // Downstream loadable up-counter sharing the reset.
   always @(posedge clk) begin
      if (rst)       cnt_out <= '0;
      else if (load) cnt_out <= cnt_in;
      else if (enab) cnt_out <= cnt_out + 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one job; cycle index k names the clock edge counted from acceptance (E0).
   task automatic run_job(input string tag, input logic [W-1:0] start, input logic [W-1:0] limit,
                          input int exp_done_k, input int exp_enab, input int exp_wrapped,
                          input int exp_final, input int pause_from, input int pause_len,
                          input int frozen_val, input int busy_req_k, input int abort_k);
      int enab_n;
      int load_n;
      int done_k;
      enab_n = 0;
      load_n = 0;
      done_k = -1;
      req_valid = 1'b1;
      req_start = start;
      req_limit = limit;
      #1;
      check({tag, "_ready_pre"}, req_ready, 1);
      tick();
      req_valid = 1'b0;
      #1;
      check({tag, "_load_e0"}, load, 1);
      check({tag, "_cnt_in"}, cnt_in, start);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ready_busy"}, req_ready, 0);
      for (int k = 1; k <= 64; k++) begin
         pause     = (k >= pause_from) && (k < pause_from + pause_len);
         req_valid = (k == busy_req_k);
         req_start = 5'd17;
         req_limit = 5'd18;
         abort     = (k == abort_k);
         #1;
         if (pause) begin
            check({tag, "_enab_paused"}, enab, 0);
            check({tag, "_cnt_frozen"}, cnt_out, frozen_val);
         end
         enab_n += int'(enab);
         load_n += int'(load);
         tick();
         if (done) begin
            done_k = k;
            break;
         end
      end
      pause     = 1'b0;
      req_valid = 1'b0;
      abort     = 1'b0;
      check({tag, "_done_edge"}, done_k, exp_done_k);
      check({tag, "_enab_cycles"}, enab_n, exp_enab);
      check({tag, "_load_cycles"}, load_n, 1);
      check({tag, "_wrapped"}, wrapped, exp_wrapped);
      check({tag, "_cnt_final"}, cnt_out, exp_final);
      check({tag, "_cnt_in_held"}, cnt_in, start);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_ready_after"}, req_ready, 1);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_start = '0;
      req_limit = '0;
      pause     = 1'b0;
      abort     = 1'b0;
      tick();
      tick();
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_load", load, 0);
      check("rst_enab", enab, 0);
      check("rst_done", done, 0);
      check("rst_wrapped", wrapped, 0);
      check("rst_cnt_in", cnt_in, 0);
      check("rst_cnt_out", cnt_out, 0);
      rst = 1'b0;
      tick();
      check("idle_ready", req_ready, 1);

      run_job("basic", 5'd3, 5'd7, 6, 4, 0, 7, 0, 0, 0, 0, 0);
      run_job("wrap", 5'd30, 5'd2, 6, 4, 1, 2, 0, 0, 0, 0, 0);
      run_job("equal", 5'd9, 5'd9, 2, 0, 0, 9, 0, 0, 0, 0, 0);
      run_job("b2b", 5'd0, 5'd1, 3, 1, 0, 1, 0, 0, 0, 0, 0);
      run_job("pause", 5'd0, 5'd5, 10, 5, 0, 5, 4, 3, 2, 2, 0);

`ifdef CNT_CTRL_ABORT_EN
      req_valid = 1'b1;
      req_start = 5'd0;
      req_limit = 5'd10;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      check("abort_cnt_before", cnt_out, 2);
      abort = 1'b1;
      #1;
      check("abort_enab", enab, 0);
      check("abort_load", load, 0);
      tick();
      abort = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_ready", req_ready, 1);
      check("abort_done", done, 0);
      check("abort_cnt_after", cnt_out, 2);
      tick();
      check("abort_done_late", done, 0);
      check("abort_cnt_hold", cnt_out, 2);
`else
      run_job("abort_off", 5'd0, 5'd10, 12, 10, 0, 10, 0, 0, 0, 0, 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
